// File: rtl/inequality_pkg.sv
// Shared types and constants for the Inequality comparator sweep sequencer.
package inequality_pkg;

  localparam int NUM_W     = 4;
  localparam int OUT_W     = 3;
  localparam int NUM_CODES = 2 ** NUM_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    FINISH
  } state_t;

  // A healthy comparator asserts exactly one of lt/eq/gt.
  function automatic logic is_onehot(input logic [OUT_W-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < OUT_W; i++) ones += int'(v[i]);
    return ones == 1;
  endfunction

endpackage

// File: rtl/inequality_result_table.sv
// Per-code result register file: synchronous write, combinational read.
module inequality_result_table
  import inequality_pkg::*;
#(
  parameter int ADDR_W = NUM_W,
  parameter int DATA_W = OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the table is cleared on reset, so it maps to flops rather than RAM; reads must return 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2 ** ADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inequality_sweep_ctrl.sv
// Sweeps every code through the Inequality comparator, records each result
// and accumulates per-bit hit counts plus a one-hot integrity flag.
module inequality_sweep_ctrl #(
  parameter int NUM_W  = 4,
  parameter int OUT_W  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [NUM_W-1:0] num,
  input  logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             done,
  input  logic [NUM_W-1:0] rd_addr,
  output logic [OUT_W-1:0] rd_data,
  output logic [NUM_W:0]   hit2,
  output logic [NUM_W:0]   hit1,
  output logic [NUM_W:0]   hit0,
  output logic             onehot_err,
  output logic [NUM_W-1:0] err_num
);

  import inequality_pkg::*;

  localparam logic [3:0]       SETTLE_L  = 4'(SETTLE);
  localparam logic [NUM_W-1:0] LAST_CODE = '1;

  state_t     state, state_next;
  logic [3:0] cnt;
  logic       we;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = WAIT;
      WAIT:    if (cnt == 4'd1) state_next = CAPTURE;
      CAPTURE: state_next = (num == LAST_CODE) ? FINISH : WAIT;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == WAIT) || (state == CAPTURE);
    done = (state == FINISH);
    we   = (state == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num        <= '0;
      cnt        <= '0;
      hit2       <= '0;
      hit1       <= '0;
      hit0       <= '0;
      onehot_err <= 1'b0;
      err_num    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            hit2       <= '0;
            hit1       <= '0;
            hit0       <= '0;
            onehot_err <= 1'b0;
            err_num    <= '0;
            cnt        <= SETTLE_L;
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        CAPTURE: begin
          hit2 <= hit2 + {{NUM_W{1'b0}}, out[2]};
          hit1 <= hit1 + {{NUM_W{1'b0}}, out[1]};
          hit0 <= hit0 + {{NUM_W{1'b0}}, out[0]};
          // Only the first failing code is remembered for the host.
          if (!is_onehot(out) && !onehot_err) begin
            onehot_err <= 1'b1;
            err_num    <= num;
          end
          num <= (num == LAST_CODE) ? '0 : num + 1'b1;
          cnt <= SETTLE_L;
        end
        FINISH:  num <= '0;
        default: num <= '0;
      endcase
    end
  end

  inequality_result_table #(
    .ADDR_W(NUM_W),
    .DATA_W(OUT_W)
  ) u_table (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(num),
    .wdata(out),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_inequality_sweep_ctrl.sv
// Scoreboard bench: stimulus pushes hand-derived sweep results, a monitor
// checks them whenever a DUT pulses done.
module tb_inequality_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic       inject = 1'b0;
  logic [3:0] rd_addr = '0;

  logic [3:0] num1, num3, err_num1, err_num3;
  logic [2:0] out1, out3, rd_data1, rd_data3;
  logic       busy1, busy3, done1, done3, err1, err3;
  logic [4:0] hit2_1, hit1_1, hit0_1, hit2_3, hit1_3, hit0_3;
  logic [3:0] d1, d2, d3;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int checked = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] ideal(input logic [3:0] k);
    return {k < 4'd11, k == 4'd11, k > 4'd11};
  endfunction

  // Stub for the SETTLE=1 unit, with optional corrupted codes 5 and 9.
  always_comb begin
    out1 = ideal(num1);
    if (inject && num1 == 4'd5) out1 = 3'b011;
    if (inject && num1 == 4'd9) out1 = 3'b000;
  end

  // Stub for the SETTLE=3 unit: result lags NUM by three cycles.
  always @(posedge clk) begin
    d1 <= num3;
    d2 <= d1;
    d3 <= d2;
  end
  assign out3 = ideal(d3);

  inequality_sweep_ctrl #(.NUM_W(4), .OUT_W(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .num(num1), .out(out1),
    .busy(busy1), .done(done1), .rd_addr(rd_addr), .rd_data(rd_data1),
    .hit2(hit2_1), .hit1(hit1_1), .hit0(hit0_1),
    .onehot_err(err1), .err_num(err_num1)
  );

  inequality_sweep_ctrl #(.NUM_W(4), .OUT_W(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .num(num3), .out(out3),
    .busy(busy3), .done(done3), .rd_addr(rd_addr), .rd_data(rd_data3),
    .hit2(hit2_3), .hit1(hit1_3), .hit0(hit0_3),
    .onehot_err(err3), .err_num(err_num3)
  );

  typedef struct {
    bit               sel;
    int               issue;
    int               lat;
    logic [4:0]       h2, h1, h0;
    logic             err;
    logic [3:0]       en;
    logic [15:0][2:0] tbl;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input bit sel, input bit inj, input int issue);
    exp_t e;
    e.sel   = sel;
    e.issue = issue;
    e.lat   = sel ? 64 : 32;
    for (int k = 0; k < 16; k++) e.tbl[k] = ideal(4'(k));
    if (inj) begin
      e.tbl[5] = 3'b011;
      e.tbl[9] = 3'b000;
      e.h2 = 5'd9;  e.h1 = 5'd2; e.h0 = 5'd5; e.err = 1'b1; e.en = 4'd5;
    end else begin
      e.h2 = 5'd11; e.h1 = 5'd1; e.h0 = 5'd4; e.err = 1'b0; e.en = 4'd0;
    end
    return e;
  endfunction

  // Monitor: every done pulse consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1 || done3) begin
        if (q.size() == 0) begin
          check("done_unexpected", {30'd0, done3, done1}, 0);
        end else begin
          e = q.pop_front();
          check("done_src",   {31'd0, done3}, {31'd0, e.sel});
          check("latency",    cyc - e.issue - 1, e.lat);
          check("busy_with_done", e.sel ? busy3 : busy1, 0);
          check("hit2",       e.sel ? hit2_3 : hit2_1, e.h2);
          check("hit1",       e.sel ? hit1_3 : hit1_1, e.h1);
          check("hit0",       e.sel ? hit0_3 : hit0_1, e.h0);
          check("onehot_err", e.sel ? err3 : err1, e.err);
          check("err_num",    e.sel ? err_num3 : err_num1, e.en);
          for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            check($sformatf("table[%0d]", a), e.sel ? rd_data3 : rd_data1, e.tbl[a]);
          end
          checked++;
        end
      end
    end
  end

  task automatic start_sweep(input bit sel, input bit inj, input bit expect_done);
    @(negedge clk);
    inject = inj;
    if (expect_done) q.push_back(make_exp(sel, inj, cyc));
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_checked(input int target);
    int n;
    n = 0;
    while (checked < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("sweep_checked", checked, target);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_num",  num1, 0);
    check("rst_hit2", hit2_1, 0);
    check("rst_hit1", hit1_1, 0);
    check("rst_hit0", hit0_1, 0);
    check("rst_err",  err1, 0);
    check("rst_errnum", err_num1, 0);
    check("rst_busy3", busy3, 0);
    rd_addr = 4'd11;
    #1 check("rst_rd_data", rd_data1, 0);

    // Ideal stub, SETTLE=1.
    start_sweep(0, 0, 1);
    wait_checked(1);

    // Corrupted codes 5 and 9.
    start_sweep(0, 1, 1);
    wait_checked(2);

    // Lagging stub on the SETTLE=3 unit.
    start_sweep(1, 0, 1);
    wait_checked(3);

    // Extra START pulses mid-sweep must be ignored.
    start_sweep(0, 0, 1);
    repeat (4) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("busy_c5", busy1, 1);
    repeat (14) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("busy_c20", busy1, 1);
    wait_checked(4);

    // Reset mid-sweep wipes everything, including the prior table.
    start_sweep(0, 0, 0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy1, 0);
    check("midrst_num",  num1, 0);
    check("midrst_hit2", hit2_1, 0);
    check("midrst_hit1", hit1_1, 0);
    check("midrst_hit0", hit0_1, 0);
    check("midrst_err",  err1, 0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1 check($sformatf("midrst_table[%0d]", a), rd_data1, 0);
    end
    start_sweep(0, 0, 1);
    wait_checked(5);

    // Reset beats a simultaneous START.
    @(negedge clk);
    reset  = 1'b1;
    start1 = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    check("rst_start_busy1", busy1, 0);
    check("rst_start_busy3", busy3, 0);
    @(negedge clk);
    check("rst_start_busy1_next", busy1, 0);
    check("rst_start_done1_next", done1, 0);

    repeat (40) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
